uart_rx: RTL and testbench

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_rx_pkg.sv | 24 ++
 rtl/uart_rx_if.sv | 10 +
 rtl/uart_rx_baud_tick.sv | 22 ++
 rtl/uart_rx.sv | 126 ++++++++++++
 tb/tb_uart_rx.sv | 177 +++++++++++++++++
 5 files changed

// File: rtl/uart_rx_pkg.sv
// Shared definitions for the UART receiver: FSM states, oversampling rate,
// the mid-bit sample positions and the 2-of-3 vote.
package uart_rx_pkg;

  localparam int unsigned OVERSAMPLE = 16;

  localparam logic [3:0] SAMPLE_A  = 4'd7;
  localparam logic [3:0] SAMPLE_B  = 4'd8;
  localparam logic [3:0] SAMPLE_C  = 4'd9;
  localparam logic [3:0] LAST_TICK = 4'(OVERSAMPLE - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK_WAIT
  } state_t;

  function automatic logic majority(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Receiver-side signal bundle: serial line in, byte and strobes out.
interface uart_rx_if;
  logic       rx;
  logic [7:0] data;
  logic       oe;
  logic       framing_error;

  modport master (input rx, output data, oe, framing_error);
  modport slave  (output rx, input data, oe, framing_error);
endinterface

// File: rtl/uart_rx_baud_tick.sv
// Free-running divider producing one oversample tick every DIVISOR clocks.
module baud_tick #(
  parameter int unsigned DIVISOR = 27
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int unsigned W = $clog2(DIVISOR);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset)                         cnt <= '0;
    else if (cnt == W'(DIVISOR - 1))   cnt <= '0;
    else                               cnt <= cnt + 1'b1;
  end

  assign tick = (cnt == W'(DIVISOR - 1));

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with 16x oversampling, majority-vote bit sampling and
// single-shot framing-error reporting on a held-low (break) line.
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int unsigned DIVISOR = 27
) (
  input  logic     clk,
  input  logic     reset,
  uart_rx_if.master bus
);

  logic       tick;
  logic       rx_meta, rx_s;
  state_t     state, state_n;
  logic [3:0] sample_cnt, sample_n;
  logic [2:0] bit_cnt, bit_n;
  logic [7:0] shift, shift_n;
  logic [7:0] data_q, data_n;
  logic       s7, s7_n, s8, s8_n;
  logic       oe_q, oe_n, fe_q, fe_n;
  logic       maj;

  baud_tick #(.DIVISOR(DIVISOR)) u_tick (
    .clk   (clk),
    .reset (reset),
    .tick  (tick)
  );

  // The vote uses the live rx_s as the third sample, so it resolves on tick 9.
  assign maj = majority(s7, s8, rx_s);

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta    <= 1'b1;
      rx_s       <= 1'b1;
      state      <= IDLE;
      sample_cnt <= '0;
      bit_cnt    <= '0;
      shift      <= '0;
      data_q     <= '0;
      s7         <= 1'b0;
      s8         <= 1'b0;
      oe_q       <= 1'b0;
      fe_q       <= 1'b0;
    end else begin
      rx_meta    <= bus.rx;
      rx_s       <= rx_meta;
      state      <= state_n;
      sample_cnt <= sample_n;
      bit_cnt    <= bit_n;
      shift      <= shift_n;
      data_q     <= data_n;
      s7         <= s7_n;
      s8         <= s8_n;
      oe_q       <= oe_n;
      fe_q       <= fe_n;
    end
  end

  always_comb begin
    state_n  = state;
    sample_n = sample_cnt;
    bit_n    = bit_cnt;
    shift_n  = shift;
    data_n   = data_q;
    s7_n     = s7;
    s8_n     = s8;
    oe_n     = 1'b0;
    fe_n     = 1'b0;
    if (tick) begin
      if (state inside {START, DATA, STOP}) begin
        sample_n = sample_cnt + 4'd1;
        if (sample_cnt == SAMPLE_A) s7_n = rx_s;
        if (sample_cnt == SAMPLE_B) s8_n = rx_s;
      end
      unique case (state)
        IDLE: begin
          if (!rx_s) begin
            state_n  = START;
            sample_n = '0;
          end
        end
        START: begin
          if (sample_cnt == SAMPLE_C && maj) begin
            state_n = IDLE;
          end else if (sample_cnt == LAST_TICK) begin
            state_n  = DATA;
            sample_n = '0;
            bit_n    = '0;
          end
        end
        DATA: begin
          if (sample_cnt == SAMPLE_C) shift_n = {maj, shift[7:1]};
          if (sample_cnt == LAST_TICK) begin
            sample_n = '0;
            if (bit_cnt == 3'd7) state_n = STOP;
            else                 bit_n   = bit_cnt + 3'd1;
          end
        end
        STOP: begin
          // Leaving at tick 9 keeps the rest of the stop bit free for start detection.
          if (sample_cnt == SAMPLE_C) begin
            if (maj) begin
              data_n  = shift;
              oe_n    = 1'b1;
              state_n = IDLE;
            end else begin
              fe_n    = 1'b1;
              state_n = BREAK_WAIT;
            end
          end
        end
        BREAK_WAIT: begin
          if (rx_s) state_n = IDLE;
        end
        default: state_n = IDLE;
      endcase
    end
  end

  assign bus.data          = data_q;
  assign bus.oe            = oe_q;
  assign bus.framing_error = fe_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at DIVISOR=4 (64 clocks per bit).
module tb_uart_rx;
  import uart_rx_pkg::*;

  localparam int BIT_CLKS = 64;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   total = 0;
  int   bad = 0;

  int         oe_cnt = 0;
  int         fe_cnt = 0;
  int         both_cnt = 0;
  int         unstable_cnt = 0;
  logic [7:0] last_data = 8'h00;
  logic [7:0] prev_data = 8'h00;
  logic [7:0] got [$];

  uart_rx_if bus ();

  uart_rx #(.DIVISOR(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.oe) begin
      oe_cnt++;
      last_data = bus.data;
      got.push_back(bus.data);
    end
    if (bus.framing_error) fe_cnt++;
    if (bus.oe && bus.framing_error) both_cnt++;
    if (!reset && !bus.oe && bus.data !== prev_data) unstable_cnt++;
    prev_data = bus.data;
  end

  task automatic send_bit(input logic b);
    bus.rx = b;
    repeat (BIT_CLKS) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(stop);
  endtask

  task automatic idle_bits(input int n);
    bus.rx = 1'b1;
    repeat (n * BIT_CLKS) @(negedge clk);
  endtask

  task automatic test_reset;
    bus.rx = 1'b1;
    reset  = 1'b1;
    repeat (5) @(negedge clk);
    total++; if (bus.data !== 8'h00) begin bad++; $display("FAIL reset_data got=%h want=00", bus.data); end
    total++; if (bus.oe !== 1'b0) begin bad++; $display("FAIL reset_oe got=%b want=0", bus.oe); end
    total++; if (bus.framing_error !== 1'b0) begin bad++; $display("FAIL reset_fe got=%b want=0", bus.framing_error); end
    total++; if (dut.state !== IDLE) begin bad++; $display("FAIL reset_state got=%0d want=%0d", dut.state, IDLE); end
    reset = 1'b0;
    idle_bits(1);
  endtask

  task automatic test_basic;
    int o0 = oe_cnt;
    int f0 = fe_cnt;
    send_frame(8'h41, 1'b1);
    idle_bits(2);
    total++; if (oe_cnt - o0 !== 1) begin bad++; $display("FAIL basic_oe_count got=%0d want=1", oe_cnt - o0); end
    total++; if (last_data !== 8'h41) begin bad++; $display("FAIL basic_data got=%h want=41", last_data); end
    total++; if (fe_cnt - f0 !== 0) begin bad++; $display("FAIL basic_fe_count got=%0d want=0", fe_cnt - f0); end
  endtask

  task automatic test_glitch;
    int o0 = oe_cnt;
    int f0 = fe_cnt;
    bus.rx = 1'b0;
    repeat (8) @(negedge clk);
    idle_bits(2);
    total++; if (oe_cnt - o0 !== 0) begin bad++; $display("FAIL glitch_oe got=%0d want=0", oe_cnt - o0); end
    total++; if (fe_cnt - f0 !== 0) begin bad++; $display("FAIL glitch_fe got=%0d want=0", fe_cnt - f0); end
    total++; if (dut.state !== IDLE) begin bad++; $display("FAIL glitch_state got=%0d want=%0d", dut.state, IDLE); end
    total++; if (bus.data !== 8'h41) begin bad++; $display("FAIL glitch_data got=%h want=41", bus.data); end
  endtask

  task automatic test_framing;
    int o0 = oe_cnt;
    int f0 = fe_cnt;
    send_frame(8'h55, 1'b0);
    idle_bits(2);
    total++; if (fe_cnt - f0 !== 1) begin bad++; $display("FAIL frame_fe got=%0d want=1", fe_cnt - f0); end
    total++; if (oe_cnt - o0 !== 0) begin bad++; $display("FAIL frame_oe got=%0d want=0", oe_cnt - o0); end
    total++; if (bus.data !== 8'h41) begin bad++; $display("FAIL frame_data_kept got=%h want=41", bus.data); end
    send_frame(8'h0A, 1'b1);
    idle_bits(2);
    total++; if (oe_cnt - o0 !== 1) begin bad++; $display("FAIL frame_next_oe got=%0d want=1", oe_cnt - o0); end
    total++; if (last_data !== 8'h0A) begin bad++; $display("FAIL frame_next_data got=%h want=0a", last_data); end
  endtask

  task automatic test_back_to_back;
    int o0 = oe_cnt;
    int n0 = got.size();
    send_frame(8'hE2, 1'b1);
    send_frame(8'h82, 1'b1);
    send_frame(8'hAC, 1'b1);
    idle_bits(2);
    total++; if (oe_cnt - o0 !== 3) begin bad++; $display("FAIL b2b_count got=%0d want=3", oe_cnt - o0); end
    total++; if (got.size() < n0 + 3 || got[n0] !== 8'hE2) begin bad++; $display("FAIL b2b_byte0 got=%h want=e2", got[n0]); end
    total++; if (got.size() < n0 + 3 || got[n0+1] !== 8'h82) begin bad++; $display("FAIL b2b_byte1 got=%h want=82", got[n0+1]); end
    total++; if (got.size() < n0 + 3 || got[n0+2] !== 8'hAC) begin bad++; $display("FAIL b2b_byte2 got=%h want=ac", got[n0+2]); end
  endtask

  task automatic test_reset_mid;
    logic [7:0] b = 8'h33;
    int o0 = oe_cnt;
    int f0 = fe_cnt;
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(b[i]);
    bus.rx = b[4];
    repeat (32) @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (32) @(negedge clk);
    idle_bits(2);
    total++; if (oe_cnt - o0 !== 0) begin bad++; $display("FAIL midreset_oe got=%0d want=0", oe_cnt - o0); end
    total++; if (fe_cnt - f0 !== 0) begin bad++; $display("FAIL midreset_fe got=%0d want=0", fe_cnt - f0); end
    total++; if (bus.data !== 8'h00) begin bad++; $display("FAIL midreset_data got=%h want=00", bus.data); end
    send_frame(8'h7E, 1'b1);
    idle_bits(2);
    total++; if (oe_cnt - o0 !== 1) begin bad++; $display("FAIL midreset_next_oe got=%0d want=1", oe_cnt - o0); end
    total++; if (last_data !== 8'h7E) begin bad++; $display("FAIL midreset_next_data got=%h want=7e", last_data); end
  endtask

  task automatic test_break;
    int o0 = oe_cnt;
    int f0 = fe_cnt;
    logic [7:0] d0 = bus.data;
    bus.rx = 1'b0;
    repeat (40 * BIT_CLKS) @(negedge clk);
    total++; if (fe_cnt - f0 !== 1) begin bad++; $display("FAIL break_fe_held got=%0d want=1", fe_cnt - f0); end
    total++; if (dut.state !== BREAK_WAIT) begin bad++; $display("FAIL break_state_held got=%0d want=%0d", dut.state, BREAK_WAIT); end
    bus.rx = 1'b1;
    repeat (10) @(negedge clk);
    total++; if (dut.state !== IDLE) begin bad++; $display("FAIL break_state_release got=%0d want=%0d", dut.state, IDLE); end
    idle_bits(2);
    total++; if (fe_cnt - f0 !== 1) begin bad++; $display("FAIL break_fe_total got=%0d want=1", fe_cnt - f0); end
    total++; if (oe_cnt - o0 !== 0) begin bad++; $display("FAIL break_oe got=%0d want=0", oe_cnt - o0); end
    total++; if (bus.data !== d0) begin bad++; $display("FAIL break_data got=%h want=%h", bus.data, d0); end
  endtask

  task automatic test_invariants;
    total++; if (both_cnt !== 0) begin bad++; $display("FAIL strobe_overlap got=%0d want=0", both_cnt); end
    total++; if (unstable_cnt !== 0) begin bad++; $display("FAIL data_stability got=%0d want=0", unstable_cnt); end
  endtask

  initial begin
    bus.rx = 1'b1;
    test_reset();
    test_basic();
    test_glitch();
    test_framing();
    test_back_to_back();
    test_reset_mid();
    test_break();
    test_invariants();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
